// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Beat counter must hold the value MAX itself, hence the extra bit.
    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats) + 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: pulses for every bit that was low last cycle and is high now.
// Latency: combinational pulse against a one-cycle history register.
// Backpressure: none; samples every cycle.
module rise_detect #(
    parameter int data_width = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] pulse
);

    logic [data_width-1:0] prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '0;
        end else begin
            prev <= din;
        end
    end

    assign pulse = din & ~prev;

endmodule

// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH word into up to MAX OUT_WIDTH beats, beat 0 from the low bits.
// Latency: first beat one cycle after acceptance, then one beat per cycle.
// Backpressure: outputs hold while rdy_downward is low; next word accepted as the last beat leaves.
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 32,
    localparam int MAX      = IN_WIDTH / OUT_WIDTH,
    localparam int CNT_W    = cnt_width(MAX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ap_start,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [CNT_W-1:0]     nbeats_in,
    input  logic                 last_in,
    input  logic                 vld_in,
    output logic                 rdy_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 last_out,
    output logic                 vld_out,
    input  logic                 rdy_downward,
    output logic                 busy
);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || MAX < 2) begin : g_bad_params
        $error("stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t                state;
    state_t                state_nxt;
    logic [IN_WIDTH-1:0]   hold;
    logic [CNT_W-1:0]      remaining;
    logic                  hold_last;
    logic [CNT_W-1:0]      n_clamped;
    logic                  clr;
    logic                  acc;
    logic                  ofire;

    rise_detect #(
        .data_width(1)
    ) u_start_edge (
        .clk  (clk),
        .reset(reset),
        .din  (ap_start),
        .pulse(clr)
    );

    assign acc       = vld_in && rdy_upward;
    assign ofire     = vld_out && rdy_downward;
    // Zero and out-of-range counts both mean a full word.
    assign n_clamped = (nbeats_in == '0 || nbeats_in > MAX_C) ? MAX_C : nbeats_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = LOAD;
        end else if (acc) begin
            state_nxt = EMIT;
        end else if (ofire && remaining == ONE_C) begin
            state_nxt = LOAD;
        end
    end

    always_comb begin
        vld_out    = (state == EMIT);
        busy       = (state == EMIT);
        rdy_upward = (state == LOAD) || (remaining == ONE_C && rdy_downward);
        dout       = hold[OUT_WIDTH-1:0];
        last_out   = hold_last && (remaining == ONE_C);
    end

    // A start edge wins over any load or shift on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            remaining <= '0;
            hold_last <= 1'b0;
        end else if (clr) begin
            hold      <= '0;
            remaining <= '0;
            hold_last <= 1'b0;
        end else if (acc) begin
            hold      <= din;
            remaining <= n_clamped;
            hold_last <= last_in;
        end else if (ofire) begin
            hold      <= hold >> OUT_WIDTH;
            remaining <= remaining - ONE_C;
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
module tb_stream_downsizer;

    localparam int IW = 128;
    localparam int OW = 32;

    typedef struct {
        logic [IW-1:0] din;
        logic [2:0]    nb;
        logic          last;
        int            exp_n;
    } vec_t;

    typedef struct {
        logic [OW-1:0] dat;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ap_start = 1'b0;
    logic [IW-1:0] din = '0;
    logic [2:0]    nbeats_in = '0;
    logic          last_in = 1'b0;
    logic          vld_in = 1'b0;
    logic          rdy_upward;
    logic [OW-1:0] dout;
    logic          last_out;
    logic          vld_out;
    logic          rdy_downward = 1'b1;
    logic          busy;

    int    n_checks = 0;
    int    n_fail = 0;
    int    exp_n = 0;
    int    rdy_mode = 0;
    int    pcnt = 0;
    logic  ap_prev = 1'b0;
    beat_t sb[$];
    vec_t  tbl[7];

    stream_downsizer #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ap_start    (ap_start),
        .din         (din),
        .nbeats_in   (nbeats_in),
        .last_in     (last_in),
        .vld_in      (vld_in),
        .rdy_upward  (rdy_upward),
        .dout        (dout),
        .last_out    (last_out),
        .vld_out     (vld_out),
        .rdy_downward(rdy_downward),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score them, advance to edge+1.
    task automatic tick(output logic accepted);
        logic          ofire, clr, stall;
        logic [OW:0]   held;
        beat_t         b;
        #4;
        accepted = vld_in && rdy_upward;
        ofire    = vld_out && rdy_downward;
        clr      = ap_start && !ap_prev;
        stall    = vld_out && !rdy_downward;
        held     = {last_out, dout};
        if (!clr) begin
            if (ofire) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {32'd0, dout}, 64'hdead);
                end else begin
                    b = sb.pop_front();
                    check("beat_dout", dout, b.dat);
                    check("beat_last", last_out, b.last);
                end
            end
            if (accepted) begin
                for (int i = 0; i < exp_n; i++) begin
                    b.dat  = din[i*OW +: OW];
                    b.last = last_in && (i == exp_n - 1);
                    sb.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
        ap_prev = ap_start;
        if (clr) sb.delete();
        if (stall && !clr) begin
            check("stall_vld", vld_out, 1'b1);
            check("stall_hold", {last_out, dout}, held);
        end
        pcnt++;
        case (rdy_mode)
            1:       rdy_downward = 1'($urandom_range(0, 1));
            2:       rdy_downward = (pcnt % 3 == 0);
            default: rdy_downward = 1'b1;
        endcase
    endtask

    task automatic send_word(input logic [IW-1:0] d, input logic [2:0] nb, input logic lst,
                             input int en, output int ticks);
        logic a;
        din       = d;
        nbeats_in = nb;
        last_in   = lst;
        exp_n     = en;
        vld_in    = 1'b1;
        ticks     = 0;
        a         = 1'b0;
        while (!a && ticks < 100) begin
            tick(a);
            ticks++;
        end
        if (!a) check("accept_timeout", 0, 1);
        vld_in = 1'b0;
    endtask

    task automatic drain(output int cycles);
        logic a;
        vld_in = 1'b0;
        cycles = 0;
        while ((sb.size() != 0 || busy) && cycles < 200) begin
            tick(a);
            cycles++;
        end
        if (cycles >= 200) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int t, c;
        logic a;

        tbl[0] = '{128'h0d0d0d0d_0c0c0c0c_0b0b0b0b_0a0a0a0a, 3'd0, 1'b0, 4};
        tbl[1] = '{128'hffffffff_eeeeeeee_dddddddd_12345678, 3'd1, 1'b0, 1};
        tbl[2] = '{128'h00000000_00000000_00000000_cafef00d, 3'd1, 1'b1, 1};
        tbl[3] = '{128'h89abcdef_01234567_fedcba98_76543210, 3'd7, 1'b1, 4};
        tbl[4] = '{128'h99999999_a5a5a5a5_5a5a5a5a_0f0f0f0f, 3'd3, 1'b0, 3};
        tbl[5] = '{128'h40404040_30303030_20202020_10101010, 3'd4, 1'b1, 4};
        tbl[6] = '{128'h77777777_66666666_beefbeef_deadbeef, 3'd2, 1'b0, 2};

        // Reset state
        #3;
        check("rst_vld_out", vld_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy_upward", rdy_upward, 1'b1);
        check("rst_dout", dout, 32'h0);
        check("rst_last_out", last_out, 1'b0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Full word, latency and throughput
        send_word(128'h44444444_33333333_22222222_11111111, 3'd0, 1'b0, 4, t);
        check("lat_vld_out", vld_out, 1'b1);
        check("lat_first_beat", dout, 32'h11111111);
        drain(c);
        check("full_word_cycles", c, 4);

        // Back-to-back words: no bubbles, accept on the 4th beat
        send_word(128'h44444444_33333333_22222222_11111111, 3'd0, 1'b0, 4, t);
        send_word(128'h88888888_77777777_66666666_55555555, 3'd4, 1'b1, 4, t);
        check("b2b_accept_tick", t, 4);
        check("b2b_vld_cont", vld_out, 1'b1);
        drain(c);
        check("b2b_second_cycles", c, 4);

        // Short word with last
        send_word(128'h0_0_bbbbbbbb_aaaaaaaa, 3'd2, 1'b1, 2, t);
        drain(c);
        check("short_cycles", c, 2);
        check("short_busy_after", busy, 1'b0);

        // Table-driven words, back-to-back, random downstream backpressure
        rdy_mode = 1;
        for (int i = 0; i < 7; i++) begin
            send_word(tbl[i].din, tbl[i].nb, tbl[i].last, tbl[i].exp_n, t);
        end
        drain(c);
        check("tbl_sb_empty", sb.size(), 0);
        check("tbl_busy_after", busy, 1'b0);

        // Stall pattern 1,0,0,1,...
        rdy_mode = 2;
        pcnt = 0;
        send_word(128'hd4d4d4d4_c3c3c3c3_b2b2b2b2_a1a1a1a1, 3'd0, 1'b1, 4, t);
        drain(c);
        check("stall_sb_empty", sb.size(), 0);
        rdy_mode = 0;
        rdy_downward = 1'b1;

        // Start edge after 2 of 4 beats discards the rest
        send_word(128'h04040404_03030303_02020202_01010101, 3'd0, 1'b0, 4, t);
        tick(a);
        tick(a);
        rdy_downward = 1'b0;
        rdy_mode = 3;
        ap_start = 1'b1;
        tick(a);
        check("clr_vld_out", vld_out, 1'b0);
        check("clr_busy", busy, 1'b0);
        rdy_mode = 0;
        rdy_downward = 1'b1;
        for (int i = 0; i < 4; i++) tick(a);
        check("clr_no_output", vld_out, 1'b0);
        ap_start = 1'b0;
        tick(a);

        // Asynchronous reset mid-word
        send_word(128'h0e0e0e0e_0d0d0d0d_0c0c0c0c_0b0b0b0b, 3'd0, 1'b1, 4, t);
        tick(a);
        #3 reset = 1'b0;
        #1;
        check("arst_vld_out", vld_out, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rdy_upward", rdy_upward, 1'b1);
        sb.delete();
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        send_word(128'h5e5e5e5e_5d5d5d5d_5c5c5c5c_5b5b5b5b, 3'd0, 1'b0, 4, t);
        check("post_rst_beat0", dout, 32'h5b5b5b5b);
        drain(c);
        check("post_rst_cycles", c, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 512, input word width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, output beat width in bits.
REQ-003 SHALL derive localparam MAX = IN_WIDTH/OUT_WIDTH and localparam CNT_W = $clog2(MAX)+1.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ap_start, input, 1, kernel start; its rising edge is a soft clear.
REQ-007 SHALL have port din, input, IN_WIDTH, packed input word; beat 0 is din[OUT_WIDTH-1:0].
REQ-008 SHALL have port nbeats_in, input, CNT_W, number of valid beats in din; 0 means MAX.
REQ-009 SHALL have port last_in, input, 1, marks the final word of a transfer.
REQ-010 SHALL have port vld_in, input, 1, and port rdy_upward, output, 1, the upstream handshake.
REQ-011 SHALL have port dout, output, OUT_WIDTH, and port last_out, output, 1, the output beat and its end-of-transfer flag.
REQ-012 SHALL have port vld_out, output, 1, and port rdy_downward, input, 1, the downstream handshake.
REQ-013 SHALL have port busy, output, 1, high while any beat of an accepted word is still pending.

Function
REQ-014 Parameter check: IN_WIDTH SHALL be an integer multiple of OUT_WIDTH with MAX >= 2; otherwise elaboration SHALL fail.
REQ-015 A transfer occurs on a cycle with valid and ready both high; data SHALL NOT be dropped or duplicated.
REQ-016 The FSM SHALL have two states: LOAD (holding register empty) and EMIT (holding register has pending beats).
REQ-017 An accepted input SHALL be captured in full (din, beat count N with 0 mapped to MAX, last_in) into a registered holding stage; the output SHALL be fully registered with no combinational din->dout path.
REQ-018 Latency SHALL be one cycle: the first beat of an accepted word SHALL appear on dout, with vld_out high, the cycle after acceptance.
REQ-019 In EMIT, each output transfer SHALL shift the holding register right by OUT_WIDTH and decrement the remaining-beat counter.
REQ-020 last_out SHALL be high only on the final beat (remaining == 1) of a word captured with last_in=1.
REQ-021 rdy_upward SHALL equal (state==LOAD) OR (remaining==1 AND rdy_downward), so a new word is accepted on the same cycle the last beat leaves; this gives zero bubbles between words.
REQ-022 Throughput SHALL be one beat per cycle under continuous rdy_downward, and N cycles per word.
REQ-023 When vld_out is high and rdy_downward is low, dout, last_out and vld_out SHALL hold stable.
REQ-024 If N == 1, the word SHALL emit exactly one beat and the block SHALL return to LOAD, or stay in EMIT if a new word is accepted on that same cycle.
REQ-025 nbeats_in greater than MAX SHALL be clamped to MAX.
REQ-026 A rising edge of ap_start SHALL act as a synchronous clear on the next clock edge, with the same effect as reset; it takes priority over any simultaneous transfer, and the data in flight is discarded.
REQ-027 busy SHALL equal (state==EMIT).

Reset
REQ-028 While reset is low, the block SHALL asynchronously force: state=LOAD, vld_out=0, last_out=0, dout=0, the holding register and remaining counter to 0, and the edge-detect register to 0.
REQ-029 While reset is low, rdy_upward SHALL be 1; accepts SHALL resume on the first clock edge after reset deasserts.
REQ-030 An assertion of reset during EMIT SHALL discard the pending beats without emitting any partial output.

Structure
REQ-031 The state encoding (LOAD/EMIT) and the beat-count width function SHALL live in a shared package, stream_pkg.
REQ-032 The ap_start edge detection SHALL be a single sub-module instance, rise_detect with data_width=1, adapted to the active-low asynchronous reset; no other sub-modules SHALL be used.

Verification (IN_WIDTH=128, OUT_WIDTH=32, MAX=4)
REQ-033 Input din=0x44444444_33333333_22222222_11111111, nbeats_in=0, rdy_downward=1 -> dout sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles, starting one cycle after acceptance.
REQ-034 Two back-to-back words with vld_in held high -> 8 consecutive output beats with no bubble; rdy_upward pulses high on the 4th beat of the first word.
REQ-035 Input nbeats_in=2, last_in=1 -> exactly 2 beats, with last_out=1 on the 2nd beat only; then busy=0.
REQ-036 rdy_downward toggling 1,0,0,1,... during EMIT -> dout holds during stalls; all 4 beats delivered in order and none lost.
REQ-037 ap_start rising edge after the 2nd of 4 beats -> vld_out=0 and busy=0 on the next cycle, and the remaining 2 beats are never emitted.
REQ-038 reset pulled low mid-word, asynchronously to clk -> vld_out drops immediately; after release, a new word emits from beat 0.
